// File: rtl/ddc_phase_sched.sv
// Phase configuration scheduler: shadows per-channel pinc/poff and streams the
// dirty (or all, on resync) channels onto a shared registered phase bus.
module ddc_phase_sched #(
  parameter int N_CH       = 8,
  parameter int CH_W       = 3,
  parameter int SETTLE_CYC = 14
) (
  input  logic              s_axis_aclk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [31:0]       cfg_data,
  input  logic              cfg_commit,
  input  logic              cfg_resync,
  output logic [63:0]       m_axis_phase_tdata,
  output logic [N_CH-1:0]   m_axis_phase_tvalid,
  output logic              resync,
  output logic              busy,
  output logic              done,
  output logic              settled
);

  // state    | meaning
  // S_IDLE   | waiting for a commit (or a pending one)
  // S_LOAD   | one channel slot per cycle, ch = 0..N_CH-1
  // S_SETTLE | waiting for the DDS/DDC pipelines to absorb the last load
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  logic [1:0]       state;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] cnt;
  logic             flag;
  logic             pending;
  logic             pend_resync;
  logic [N_CH-1:0]  dirty;
  logic [N_CH-1:0]  dirty_nxt;
  logic [31:0]      pinc_sh [N_CH];
  logic [31:0]      poff_sh [N_CH];
  logic             slot_hit;
  logic             start;

  assign slot_hit = (state == S_LOAD) && (dirty[ch] || flag);
  assign start    = (state == S_IDLE) && (cfg_commit || pending);

  // A write in the same cycle as the slot must keep the channel dirty.
  always_comb begin
    dirty_nxt = dirty;
    if (slot_hit)
      dirty_nxt[ch] = 1'b0;
    if (cfg_wr_en)
      dirty_nxt[cfg_ch] = 1'b1;
  end

  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      dirty <= '0;
      for (int i = 0; i < N_CH; i++) begin
        pinc_sh[i] <= '0;
        poff_sh[i] <= '0;
      end
    end else begin
      dirty <= dirty_nxt;
      if (cfg_wr_en) begin
        if (cfg_sel)
          poff_sh[cfg_ch] <= cfg_data;
        else
          pinc_sh[cfg_ch] <= cfg_data;
      end
    end
  end

  // Commits arriving outside IDLE collapse into one pending request.
  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      pend_resync <= 1'b0;
    end else if (start) begin
      pending     <= 1'b0;
      pend_resync <= 1'b0;
    end else if (cfg_commit) begin
      pending     <= 1'b1;
      pend_resync <= pend_resync | cfg_resync;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ch      <= '0;
      cnt     <= '0;
      flag    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      settled <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            ch      <= '0;
            flag    <= (cfg_commit & cfg_resync) | pend_resync;
            busy    <= 1'b1;
            settled <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ch == CH_W'(N_CH - 1)) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        S_SETTLE: begin
          // Settle time runs from the cycle the last strobe is on the bus.
          if (cnt == CNT_W'(SETTLE_CYC)) begin
            state   <= S_IDLE;
            done    <= 1'b1;
            settled <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      m_axis_phase_tdata  <= '0;
      m_axis_phase_tvalid <= '0;
      resync              <= 1'b0;
    end else begin
      m_axis_phase_tvalid <= slot_hit ? ({{(N_CH-1){1'b0}}, 1'b1} << ch) : '0;
      resync              <= slot_hit & flag;
      if (slot_hit)
        m_axis_phase_tdata <= {poff_sh[ch], pinc_sh[ch]};
    end
  end

endmodule

// File: tb/tb_ddc_phase_sched.sv
// Bench for ddc_phase_sched: directed scenarios plus random traffic, all
// outputs compared every cycle against a slot-timing reference model.
module tb_ddc_phase_sched;
  localparam int N_CH   = 8;
  localparam int CH_W   = 3;
  localparam int SETTLE = 14;

  logic              s_axis_aclk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_wr_en = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic              cfg_sel = 1'b0;
  logic [31:0]       cfg_data = '0;
  logic              cfg_commit = 1'b0;
  logic              cfg_resync = 1'b0;
  logic [63:0]       m_axis_phase_tdata;
  logic [N_CH-1:0]   m_axis_phase_tvalid;
  logic              resync;
  logic              busy;
  logic              done;
  logic              settled;

  ddc_phase_sched #(.N_CH(N_CH), .CH_W(CH_W), .SETTLE_CYC(SETTLE)) dut (
    .s_axis_aclk(s_axis_aclk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_resync(cfg_resync),
    .m_axis_phase_tdata(m_axis_phase_tdata), .m_axis_phase_tvalid(m_axis_phase_tvalid),
    .resync(resync), .busy(busy), .done(done), .settled(settled)
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a sequence starting at cycle S evaluates slot k in cycle
  // S+k (strobe visible in S+k+1) and reports done in S+N_CH+1+SETTLE.
  logic [31:0]     m_pinc [N_CH];
  logic [31:0]     m_poff [N_CH];
  bit              m_dirty [N_CH];
  bit              m_active, m_flag, m_pend, m_pres;
  int              seq_s, seq_d, cyc;
  logic [63:0]     e_data;
  logic [N_CH-1:0] e_valid;
  logic            e_resync, e_busy, e_done, e_settled;

  int              valid_cnt, done_cnt, first_valid_at, done_at;
  logic [N_CH-1:0] last_valid;
  logic [63:0]     last_data, ch2_data;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_pinc[i] = '0; m_poff[i] = '0; m_dirty[i] = 0;
    end
    m_active = 0; m_flag = 0; m_pend = 0; m_pres = 0;
    seq_s = 0; seq_d = 0;
    e_data = '0; e_valid = '0; e_resync = 0; e_busy = 0; e_done = 0; e_settled = 0;
  endtask

  task automatic model_step();
    bit idle;
    int k;
    e_valid = '0; e_resync = 0; e_done = 0;
    if (m_active && cyc >= seq_s && cyc < seq_s + N_CH) begin
      k = cyc - seq_s;
      if (m_dirty[k] || m_flag) begin
        e_valid    = N_CH'(1) << k;
        e_data     = {m_poff[k], m_pinc[k]};
        e_resync   = m_flag;
        m_dirty[k] = 0;
      end
    end
    if (m_active && cyc + 1 == seq_d) begin
      e_done = 1; e_settled = 1;
    end
    if (cfg_wr_en) begin
      if (cfg_sel) m_poff[cfg_ch] = cfg_data;
      else         m_pinc[cfg_ch] = cfg_data;
      m_dirty[cfg_ch] = 1;
    end
    idle = !m_active || cyc >= seq_d;
    if (idle && (cfg_commit || m_pend)) begin
      m_flag = (cfg_commit && cfg_resync) || m_pres;
      m_pend = 0; m_pres = 0;
      seq_s = cyc + 1;
      seq_d = seq_s + N_CH + 1 + SETTLE;
      m_active = 1;
      e_settled = 0;
    end else if (cfg_commit) begin
      m_pend = 1;
      m_pres = m_pres | cfg_resync;
    end
    e_busy = m_active && (cyc + 1 >= seq_s) && (cyc + 1 <= seq_d);
  endtask

  task automatic compare_outputs();
    check_val("tvalid", 64'(m_axis_phase_tvalid), 64'(e_valid));
    check_val("tdata", m_axis_phase_tdata, e_data);
    check_val("resync", 64'(resync), 64'(e_resync));
    check_val("busy", 64'(busy), 64'(e_busy));
    check_val("done", 64'(done), 64'(e_done));
    check_val("settled", 64'(settled), 64'(e_settled));
  endtask

  task automatic clear_log();
    valid_cnt = 0; done_cnt = 0; first_valid_at = -1; done_at = -1;
    last_valid = '0; last_data = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge s_axis_aclk);
    #1;
    compare_outputs();
    if (m_axis_phase_tvalid != '0) begin
      valid_cnt++;
      if (first_valid_at < 0) first_valid_at = cyc + 1;
      last_valid = m_axis_phase_tvalid;
      last_data  = m_axis_phase_tdata;
      if (m_axis_phase_tvalid == 8'h04) ch2_data = m_axis_phase_tdata;
    end
    if (done) begin
      done_cnt++;
      done_at = cyc + 1;
    end
    cyc++;
  endtask

  task automatic idle_in();
    cfg_wr_en = 0; cfg_ch = '0; cfg_sel = 0; cfg_data = '0; cfg_commit = 0; cfg_resync = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int ch, input bit sel, input logic [31:0] data);
    cfg_wr_en = 1; cfg_ch = CH_W'(ch); cfg_sel = sel; cfg_data = data;
    tick();
    idle_in();
  endtask

  task automatic commit(input bit res, output int t);
    cfg_commit = 1; cfg_resync = res; t = cyc;
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1;
    idle_in();
    model_reset();
    #1;
    compare_outputs();
    @(posedge s_axis_aclk);
    #1;
    compare_outputs();
    rst = 0;
    cyc = 0;
  endtask

  initial begin
    int t;
    ch2_data = '0;
    clear_log();
    do_reset();

    // 1: single channel load
    wr(3, 0, 32'h1000_0000);
    wr(3, 1, 32'h0000_0040);
    clear_log();
    commit(0, t);
    run(30);
    check_val("t1_first_valid", 64'(first_valid_at - t), 64'd5);
    check_val("t1_valid_cnt", 64'(valid_cnt), 64'd1);
    check_val("t1_valid", 64'(last_valid), 64'h08);
    check_val("t1_data", last_data, 64'h0000_0040_1000_0000);
    check_val("t1_done", 64'(done_at - t), 64'd24);

    // 2: resync loads every channel
    wr(0, 0, 32'hAAAA_0001);
    wr(7, 1, 32'h7777_0007);
    clear_log();
    commit(1, t);
    run(30);
    check_val("t2_valid_cnt", 64'(valid_cnt), 64'd8);
    check_val("t2_last_valid", 64'(last_valid), 64'h80);

    // 3: commit during SETTLE queues a second sequence
    wr(5, 0, 32'h5555_5555);
    clear_log();
    commit(0, t);
    run(12);
    cfg_commit = 1; cfg_resync = 0;
    tick();
    idle_in();
    run(60);
    check_val("t3_done_cnt", 64'(done_cnt), 64'd2);

    // 4: write collides with its own slot
    wr(2, 0, 32'h0000_0A0A);
    commit(0, t);
    run(2);
    wr(2, 0, 32'h0000_0B0B);
    run(30);
    check_val("t4_old_data", 64'(ch2_data[31:0]), 64'h0A0A);
    commit(0, t);
    run(30);
    check_val("t4_new_data", 64'(ch2_data[31:0]), 64'h0B0B);

    // 5: reset in the middle of LOAD
    for (int i = 0; i < 8; i++) wr(i, i[0], $urandom);
    commit(0, t);
    for (int i = 0; i < 10 && cyc < seq_s + 4; i++) tick();
    do_reset();
    clear_log();
    commit(0, t);
    run(30);
    check_val("t5_valid_cnt", 64'(valid_cnt), 64'd0);

    // 6: empty commit still runs the full sequence
    clear_log();
    commit(0, t);
    run(30);
    check_val("t6_valid_cnt", 64'(valid_cnt), 64'd0);
    check_val("t6_done", 64'(done_at - t), 64'(2 + N_CH + SETTLE));

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cfg_wr_en  = ($urandom_range(0, 9) < 3);
      cfg_ch     = CH_W'($urandom_range(0, N_CH - 1));
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_data   = $urandom;
      cfg_commit = ($urandom_range(0, 99) < 4);
      cfg_resync = ($urandom_range(0, 9) < 3);
      tick();
    end
    idle_in();
    run(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
